// File: rtl/wavelet_tap_window.sv
`default_nettype none
// ============================================================================
//  Module   : wavelet_tap_window
//  Purpose  : Sliding tap window feeding the wavelet FIR filter bank. Holds
//             the most recent NUM_ELEM unsigned samples as a packed bus,
//             tracks how full the window is, and issues a decimated strobe
//             marking windows that are fresh and fully populated.
//  Ports    : clk          - clock, rising edge
//             rst_n        - asynchronous active-low reset
//             sample_in    - unsigned input sample
//             sample_valid - sample_in accepted on this edge
//             flush        - synchronous clear of window and counters
//             taps         - packed window, element 0 (newest) in the LSBs
//             taps_valid   - one-cycle strobe, full window on decimation phase
//             window_full  - level, NUM_ELEM samples held
//             fill_count   - samples held, saturating at NUM_ELEM
//  Revision : 1.0 - initial release
// ============================================================================
module wavelet_tap_window #(
    parameter int BITS_PER_ELEM = 8,
    parameter int NUM_ELEM      = 7,
    parameter int DECIMATE      = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [BITS_PER_ELEM-1:0]          sample_in,
    input  logic                              sample_valid,
    input  logic                              flush,
    output logic [NUM_ELEM*BITS_PER_ELEM-1:0] taps,
    output logic                              taps_valid,
    output logic                              window_full,
    output logic [$clog2(NUM_ELEM+1)-1:0]     fill_count
);

    localparam int c_w  = NUM_ELEM * BITS_PER_ELEM;
    localparam int c_fw = $clog2(NUM_ELEM + 1);
    // A decimation counter still needs one bit when DECIMATE = 1.
    localparam int c_cw = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;

    localparam logic [c_fw-1:0] c_fill_max = c_fw'(NUM_ELEM);
    localparam logic [c_cw-1:0] c_dec_last = c_cw'(DECIMATE - 1);

    logic [c_w-1:0]  taps_q,  taps_d;
    logic            tv_q,    tv_d;
    logic            full_q,  full_d;
    logic [c_fw-1:0] fill_q,  fill_d;
    logic [c_cw-1:0] dec_q,   dec_d;

    always_comb begin
        taps_d = taps_q;
        tv_d   = 1'b0;
        fill_d = fill_q;
        full_d = full_q;
        dec_d  = dec_q;

        if (flush) begin
            // Flush wins over a coincident sample, which is dropped.
            taps_d = '0;
            fill_d = '0;
            full_d = 1'b0;
            dec_d  = '0;
        end else if (sample_valid) begin
            taps_d = {taps_q[c_w-BITS_PER_ELEM-1:0], sample_in};
            fill_d = (fill_q == c_fill_max) ? fill_q : fill_q + 1'b1;
            full_d = (fill_d == c_fill_max);
            // The phase counter only runs once the post-shift window is full,
            // so the first strobe lands on the sample completing the window.
            if (full_d) begin
                tv_d  = (dec_q == '0);
                dec_d = (dec_q == c_dec_last) ? '0 : dec_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps_q <= '0;
            tv_q   <= 1'b0;
            fill_q <= '0;
            full_q <= 1'b0;
            dec_q  <= '0;
        end else begin
            taps_q <= taps_d;
            tv_q   <= tv_d;
            fill_q <= fill_d;
            full_q <= full_d;
            dec_q  <= dec_d;
        end
    end

    assign taps        = taps_q;
    assign taps_valid  = tv_q;
    assign window_full = full_q;
    assign fill_count  = fill_q;

endmodule
`default_nettype wire

// File: tb/tb_wavelet_tap_window.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wavelet_tap_window
//  Purpose  : Scoreboard bench for wavelet_tap_window. Two instances share
//             the stimulus: DECIMATE = 1 (A) and DECIMATE = 3 (B).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wavelet_tap_window;

    typedef struct packed {
        logic [55:0] taps;
        logic        tv_a;
        logic        tv_b;
        logic [2:0]  fill;
        logic        full;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        flush = 1'b0;

    logic [55:0] taps_a,  taps_b;
    logic        tv_a,    tv_b;
    logic        full_a,  full_b;
    logic [2:0]  fill_a,  fill_b;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    wavelet_tap_window #(.BITS_PER_ELEM(8), .NUM_ELEM(7), .DECIMATE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in),
        .sample_valid(sample_valid), .flush(flush),
        .taps(taps_a), .taps_valid(tv_a), .window_full(full_a), .fill_count(fill_a)
    );

    wavelet_tap_window #(.BITS_PER_ELEM(8), .NUM_ELEM(7), .DECIMATE(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in),
        .sample_valid(sample_valid), .flush(flush),
        .taps(taps_b), .taps_valid(tv_b), .window_full(full_b), .fill_count(fill_b)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Window after the k-th consecutive sample with values 1..k since a clear.
    function automatic exp_t exp_fill(int k);
        exp_t e;
        int   cnt;
        e   = '0;
        cnt = (k < 7) ? k : 7;
        for (int i = 0; i < cnt; i++) e.taps[8*i +: 8] = 8'(k - i);
        e.fill = 3'(cnt);
        e.full = (k >= 7);
        e.tv_a = (k >= 7);
        e.tv_b = (k >= 7) && (((k - 7) % 3) == 0);
        return e;
    endfunction

    function automatic exp_t exp_hold(exp_t e);
        exp_t h;
        h      = e;
        h.tv_a = 1'b0;
        h.tv_b = 1'b0;
        return h;
    endfunction

    task automatic step(logic v, logic [7:0] d, logic f, exp_t e);
        @(negedge clk);
        sample_valid = v;
        sample_in    = d;
        flush        = f;
        sb.push_back(e);
    endtask

    task automatic check_zero(string tag);
        check({tag, ".taps_a"}, 64'(taps_a), 64'd0);
        check({tag, ".tv_a"},   64'(tv_a),   64'd0);
        check({tag, ".full_a"}, 64'(full_a), 64'd0);
        check({tag, ".fill_a"}, 64'(fill_a), 64'd0);
        check({tag, ".taps_b"}, 64'(taps_b), 64'd0);
        check({tag, ".fill_b"}, 64'(fill_b), 64'd0);
    endtask

    // Monitor: one expectation per driven cycle, checked after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("taps_a",  64'(taps_a), 64'(e.taps));
                check("tv_a",    64'(tv_a),   64'(e.tv_a));
                check("full_a",  64'(full_a), 64'(e.full));
                check("fill_a",  64'(fill_a), 64'(e.fill));
                check("taps_b",  64'(taps_b), 64'(e.taps));
                check("tv_b",    64'(tv_b),   64'(e.tv_b));
                check("fill_b",  64'(fill_b), 64'(e.fill));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t last;
        int   gaps[4] = '{0, 1, 2, 3};

        // Reset state
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with 1..8: single strobe on A at 7 and 8, on B only at 7
        for (int k = 1; k <= 8; k++) step(1'b1, 8'(k), 1'b0, exp_fill(k));

        // Flush with a coincident sample 0xAA: everything clears
        step(1'b1, 8'hAA, 1'b1, exp_t'(0));
        step(1'b0, 8'h00, 1'b0, exp_t'(0));

        // Refill 1..13: A strobes from 7 on, B at 7, 10 and 13
        for (int k = 1; k <= 13; k++) step(1'b1, 8'(k), 1'b0, exp_fill(k));

        // Gapped samples 1..4 after a flush
        step(1'b0, 8'h00, 1'b1, exp_t'(0));
        last = '0;
        for (int k = 1; k <= 4; k++) begin
            for (int g = 0; g < gaps[k-1]; g++)
                step(1'b0, 8'hEE, 1'b0, exp_hold(last));
            last = exp_fill(k);
            step(1'b1, 8'(k), 1'b0, last);
        end
        step(1'b0, 8'hEE, 1'b0, exp_hold(last));
        step(1'b1, 8'd5, 1'b0, exp_fill(5));
        step(1'b0, 8'h00, 1'b0, exp_hold(exp_fill(5)));

        // Asynchronous reset between edges after 5 samples
        @(posedge clk);
        #2;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) step(1'b1, 8'(k), 1'b0, exp_fill(k));
        step(1'b0, 8'h00, 1'b0, exp_hold(exp_fill(3)));

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        check("drain", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wavelet_tap_window.md
Name: wavelet_tap_window

Overview:
- Upstream stage of the wavelet FIR filter bank.
- Accepts a stream of unsigned samples, one per sample_valid strobe, and holds the most recent NUM_ELEM samples as a packed taps bus. The bus drives every fir instance in the bank directly.
- Tracks window fill and issues a decimated taps_valid strobe so downstream capture logic knows which fir sums correspond to a fresh, fully populated window.

Parameters:
- BITS_PER_ELEM, 8, width of one sample and of one taps element.
- NUM_ELEM, 7, window length; must match the fir NUM_ELEM; legal range 2..64.
- DECIMATE, 1, emit taps_valid once every DECIMATE accepted samples after the window is full; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sample_in  input  BITS_PER_ELEM  unsigned input sample.
- sample_valid  input  1  sample_in is accepted on this clock edge.
- flush  input  1  synchronous clear of window and counters.
- taps  output  NUM_ELEM*BITS_PER_ELEM  packed window; element i is at bits [BITS_PER_ELEM*i +: BITS_PER_ELEM]; element 0 is the newest sample.
- taps_valid  output  1  one-cycle strobe: taps holds a full window, aligned to decimation.
- window_full  output  1  level; at least NUM_ELEM samples accepted since reset or flush.
- fill_count  output  $clog2(NUM_ELEM+1)  samples held, saturating at NUM_ELEM.

Behaviour:
- Reset (rst_n low, asynchronous):
  - taps = 0, taps_valid = 0, window_full = 0, fill_count = 0.
  - Decimation counter = 0.
  - Reset asserted mid-stream discards all held samples immediately, without waiting for a clock edge.
- Accepted sample (sample_valid = 1, flush = 0, on a rising edge):
  - Element i+1 takes element i for i = 0..NUM_ELEM-2; element 0 takes sample_in.
  - The oldest element is discarded.
  - taps is registered, so the new value is visible the cycle after acceptance.
- No shift while sample_valid = 0; taps holds its value indefinitely.
- fill_count increments by 1 per accepted sample and saturates at NUM_ELEM; it never wraps.
- window_full = (fill_count == NUM_ELEM), registered together with fill_count.
- Decimation counter (range 0..DECIMATE-1):
  - Advances only on accepted samples where, after the update, the window is full.
  - taps_valid is asserted in the same registered cycle as the taps update when the window is full after the shift and the counter was 0 before the shift.
  - The counter then advances, wrapping DECIMATE-1 -> 0.
  - Consequence: the first strobe comes on the sample that completes the window; subsequent strobes come every DECIMATE accepted samples.
  - DECIMATE = 1: strobe on every accepted sample once full.
- taps_valid is high for exactly one cycle per qualifying sample. Back-to-back accepted samples with DECIMATE = 1 give a continuously high strobe.
- flush = 1 on an edge:
  - taps = 0, fill_count = 0, window_full = 0, decimation counter = 0, taps_valid = 0.
  - flush has priority: a simultaneous sample_valid is discarded.
- Downstream timing: a fir instance sums taps one clock after they change. Capture logic must therefore sample output_sum one cycle after taps_valid. This block adds exactly 1 cycle of latency from sample_valid to taps.
- No arithmetic on samples; values pass through unmodified and unsigned.
- All outputs are driven from registers; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then 7 accepted samples 1..7 on consecutive cycles (defaults) -> fill_count steps 1..7; taps_valid pulses once, the cycle after sample 7 is accepted; taps = {8'd1,8'd2,8'd3,8'd4,8'd5,8'd6,8'd7} (MSB..LSB); window_full = 1.
- Continue with sample 8 -> taps = {8'd2,...,8'd8}; taps_valid high again; fill_count stays 7.
- DECIMATE=3, feed samples 1..13 -> taps_valid pulses after samples 7, 10 and 13 only; taps at the last pulse = {8'd7,...,8'd13}.
- Samples 1..4 with sample_valid gaps of 0-3 idle cycles -> taps changes only on accepted edges; fill_count = 4; no taps_valid; taps stable during gaps.
- After a full window, assert flush together with sample_valid (sample 0xAA) -> taps = 0, fill_count = 0, window_full = 0, taps_valid = 0; 0xAA is not present; 7 more samples are needed for the next strobe.
- Drop rst_n asynchronously between clock edges after 5 samples -> all outputs 0 before the next edge; the subsequent fill restarts from fill_count 1.
